// File: rtl/lc3_datapath_p.sv
// W-bit LC-3 datapath: register file, PC/IR/MAR/MDR/LED, ALU, address adder,
// one-hot gated bus with sticky contention flag, NZP condition codes and BEN.
module lc3_datapath_p #(
  parameter int W     = 16,
  parameter int LED_W = 12
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_IR,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_REG,
  input  logic             LD_PC,
  input  logic             LD_LED,
  input  logic             GatePC,
  input  logic             GateMDR,
  input  logic             GateALU,
  input  logic             GateMARMUX,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic             SR2MUX,
  input  logic             ADDR1MUX,
  input  logic             MIO_EN,
  input  logic [1:0]       ADDR2MUX,
  input  logic [1:0]       ALUK,
  input  logic [1:0]       PCMUX,
  input  logic [W-1:0]     MDR_In,
  output logic             BEN,
  output logic [2:0]       NZP,
  output logic             BusErr,
  output logic [W-1:0]     Bus,
  output logic [LED_W-1:0] LED,
  output logic [W-1:0]     IR,
  output logic [W-1:0]     MAR,
  output logic [W-1:0]     MDR,
  output logic [W-1:0]     PC
);

  function automatic logic [W-1:0] sext5(input logic [4:0] v);
    return {{(W-5){v[4]}}, v};
  endfunction

  function automatic logic [W-1:0] sext6(input logic [5:0] v);
    return {{(W-6){v[5]}}, v};
  endfunction

  function automatic logic [W-1:0] sext9(input logic [8:0] v);
    return {{(W-9){v[8]}}, v};
  endfunction

  function automatic logic [W-1:0] sext11(input logic [10:0] v);
    return {{(W-11){v[10]}}, v};
  endfunction

  logic [W-1:0] regs [8];
  logic [2:0]   dr;
  logic [2:0]   sr1;
  logic [W-1:0] sr1_val;
  logic [W-1:0] opnd_b;
  logic [W-1:0] alu;
  logic [W-1:0] base;
  logic [W-1:0] offset;
  logic [W-1:0] addr_sum;
  logic [W-1:0] pc_next;
  logic [3:0]   gates;
  logic         contention;

  assign dr      = DRMUX  ? 3'd7      : IR[11:9];
  assign sr1     = SR1MUX ? IR[8:6]   : IR[11:9];
  assign sr1_val = regs[sr1];
  assign opnd_b  = SR2MUX ? sext5(IR[4:0]) : regs[IR[2:0]];

  always_comb begin
    case (ALUK)
      2'b00:   alu = sr1_val + opnd_b;
      2'b01:   alu = sr1_val & opnd_b;
      2'b10:   alu = ~sr1_val;
      default: alu = sr1_val;
    endcase
  end

  assign base = ADDR1MUX ? sr1_val : PC;

  always_comb begin
    case (ADDR2MUX)
      2'b00:   offset = '0;
      2'b01:   offset = sext6(IR[5:0]);
      2'b10:   offset = sext9(IR[8:0]);
      default: offset = sext11(IR[10:0]);
    endcase
  end

  assign addr_sum = base + offset;

  // Any pattern other than exactly one gate leaves the bus at zero.
  assign gates      = {GatePC, GateMDR, GateALU, GateMARMUX};
  assign contention = $countones(gates) > 1;

  always_comb begin
    case (gates)
      4'b1000: Bus = PC;
      4'b0100: Bus = MDR;
      4'b0010: Bus = alu;
      4'b0001: Bus = addr_sum;
      default: Bus = '0;
    endcase
  end

  always_comb begin
    case (PCMUX)
      2'b00:   pc_next = PC + W'(1);
      2'b01:   pc_next = Bus;
      2'b10:   pc_next = addr_sum;
      default: pc_next = PC;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      PC     <= '0;
      IR     <= '0;
      MAR    <= '0;
      MDR    <= '0;
      LED    <= '0;
      NZP    <= 3'b010;
      BEN    <= 1'b0;
      BusErr <= 1'b0;
    end else begin
      if (LD_REG) regs[dr] <= Bus;
      if (LD_PC)  PC  <= pc_next;
      if (LD_IR)  IR  <= Bus;
      if (LD_MAR) MAR <= Bus;
      if (LD_MDR) MDR <= MIO_EN ? MDR_In : Bus;
      if (LD_LED) LED <= IR[LED_W-1:0];
      if (LD_CC)  NZP <= Bus[W-1] ? 3'b100 : ((Bus == '0) ? 3'b010 : 3'b001);
      // BEN samples the pre-edge IR and NZP even when they load together.
      if (LD_BEN) BEN <= |(IR[11:9] & NZP);
      if (contention) BusErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lc3_datapath_p.sv
// Bench for lc3_datapath_p: directed scenarios plus randomized cycles checked
// against a behavioural model of the datapath; a W=24 instance shares inputs.
module tb_lc3_datapath_p;

  logic        Clk, Reset;
  logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic [1:0]  ADDR2MUX, ALUK, PCMUX;
  logic [15:0] MDR_In;
  logic [23:0] mdr_in24;

  logic        ben, bus_err;
  logic [2:0]  nzp;
  logic [15:0] bus, ir, mar, mdr, pc;
  logic [11:0] led;
  logic        ben24, bus_err24;
  logic [2:0]  nzp24;
  logic [23:0] bus24, ir24, mar24, mdr24, pc24;
  logic [11:0] led24;

  int checks = 0;
  int errors = 0;

  assign mdr_in24 = {8'h00, MDR_In};

  lc3_datapath_p #(.W(16), .LED_W(12)) dut (
    .Clk(Clk), .Reset(Reset),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .MIO_EN(MIO_EN), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .PCMUX(PCMUX),
    .MDR_In(MDR_In), .BEN(ben), .NZP(nzp), .BusErr(bus_err), .Bus(bus),
    .LED(led), .IR(ir), .MAR(mar), .MDR(mdr), .PC(pc)
  );

  lc3_datapath_p #(.W(24), .LED_W(12)) dut24 (
    .Clk(Clk), .Reset(Reset),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .MIO_EN(MIO_EN), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .PCMUX(PCMUX),
    .MDR_In(mdr_in24), .BEN(ben24), .NZP(nzp24), .BusErr(bus_err24), .Bus(bus24),
    .LED(led24), .IR(ir24), .MAR(mar24), .MDR(mdr24), .PC(pc24)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural model (W=16)
  logic [15:0] m_r [8];
  logic [15:0] m_pc, m_ir, m_mar, m_mdr;
  logic [11:0] m_led;
  logic [2:0]  m_nzp;
  logic        m_ben, m_err;

  function automatic logic [15:0] sx(input logic [15:0] v, input int n);
    logic signed [15:0] t;
    t = v << (16 - n);
    return t >>> (16 - n);
  endfunction

  function automatic int n_gates();
    return int'(GatePC) + int'(GateMDR) + int'(GateALU) + int'(GateMARMUX);
  endfunction

  function automatic logic [15:0] m_src_a();
    return SR1MUX ? m_r[m_ir[8:6]] : m_r[m_ir[11:9]];
  endfunction

  function automatic logic [15:0] m_alu();
    logic [15:0] a, b;
    a = m_src_a();
    b = SR2MUX ? sx(m_ir, 5) : m_r[m_ir[2:0]];
    case (ALUK)
      2'd0:    return a + b;
      2'd1:    return a & b;
      2'd2:    return ~a;
      default: return a;
    endcase
  endfunction

  function automatic logic [15:0] m_sum();
    logic [15:0] base, off;
    base = ADDR1MUX ? m_src_a() : m_pc;
    case (ADDR2MUX)
      2'd0:    off = 16'h0;
      2'd1:    off = sx(m_ir, 6);
      2'd2:    off = sx(m_ir, 9);
      default: off = sx(m_ir, 11);
    endcase
    return base + off;
  endfunction

  function automatic logic [15:0] model_bus();
    if (n_gates() != 1) return 16'h0;
    if (GatePC)  return m_pc;
    if (GateMDR) return m_mdr;
    if (GateALU) return m_alu();
    return m_sum();
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
    m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_led = 0;
    m_nzp = 3'b010; m_ben = 0; m_err = 0;
  endtask

  task automatic model_tick();
    logic [15:0] b, s;
    b = model_bus();
    s = m_sum();
    if (n_gates() > 1) m_err = 1'b1;
    if (LD_BEN) m_ben = (m_ir[11:9] & m_nzp) != 3'b000;
    if (LD_LED) m_led = m_ir[11:0];
    if (LD_CC) m_nzp = ($signed(b) < 0) ? 3'b100 : (b == 0 ? 3'b010 : 3'b001);
    if (LD_PC)
      case (PCMUX)
        2'd0: m_pc = m_pc + 16'd1;
        2'd1: m_pc = b;
        2'd2: m_pc = s;
        default: ;
      endcase
    if (LD_REG) m_r[DRMUX ? 3'd7 : m_ir[11:9]] = b;
    if (LD_IR)  m_ir = b;
    if (LD_MAR) m_mar = b;
    if (LD_MDR) m_mdr = MIO_EN ? MDR_In : b;
  endtask

  // Stimulus helpers
  task automatic idle();
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
    {DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN} = '0;
    ADDR2MUX = 0; ALUK = 0; PCMUX = 0; MDR_In = 0;
  endtask

  task automatic step();
    @(posedge Clk);
    model_tick();
    #1;
  endtask

  task automatic set_mdr(input logic [15:0] v);
    idle(); MIO_EN = 1; MDR_In = v; LD_MDR = 1; step(); idle();
  endtask

  task automatic set_ir(input logic [15:0] v);
    set_mdr(v); GateMDR = 1; LD_IR = 1; step(); idle();
  endtask

  task automatic set_reg(input logic [2:0] d, input logic [15:0] v);
    set_ir({4'h0, d, 9'h0});
    set_mdr(v); GateMDR = 1; LD_REG = 1; step(); idle();
  endtask

  task automatic set_pc(input logic [15:0] v);
    set_mdr(v); GateMDR = 1; PCMUX = 2'd1; LD_PC = 1; step(); idle();
  endtask

  // Tests
  task automatic test_reset();
    idle(); Reset = 0; model_reset();
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (pc !== 16'h0 || ir !== 16'h0 || mar !== 16'h0 || mdr !== 16'h0) begin
      errors++; $display("FAIL reset_regs: pc=%h ir=%h mar=%h mdr=%h required all 0", pc, ir, mar, mdr); end
    checks++; if (nzp !== 3'b010 || ben !== 1'b0 || bus_err !== 1'b0 || led !== 12'h0) begin
      errors++; $display("FAIL reset_flags: nzp=%b ben=%b err=%b led=%h required 010 0 0 000", nzp, ben, bus_err, led); end
    Reset = 1;
    PCMUX = 2'd0; LD_PC = 1;
    repeat (3) step();
    idle();
    checks++; if (pc !== 16'd3) begin errors++; $display("FAIL fetch_pc: got %h required 0003", pc); end
    checks++; if (pc24 !== 24'd3) begin errors++; $display("FAIL fetch_pc24: got %h required 000003", pc24); end
    checks++; if (nzp !== 3'b010 || ben !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL fetch_flags: nzp=%b ben=%b err=%b required 010 0 0", nzp, ben, bus_err); end
  endtask

  task automatic test_w24();
    set_ir(16'h0100);
    ADDR1MUX = 0; ADDR2MUX = 2'd2; GateMARMUX = 1;
    #1;
    checks++; if (bus24 !== 24'hFFFF03) begin errors++; $display("FAIL w24_bus: got %h required ffff03", bus24); end
    checks++; if (bus !== 16'hFF03) begin errors++; $display("FAIL w16_bus: got %h required ff03", bus); end
    GateMARMUX = 0; PCMUX = 2'd2; LD_PC = 1;
    step(); idle();
    checks++; if (pc24 !== 24'hFFFF03) begin errors++; $display("FAIL w24_pc: got %h required ffff03", pc24); end
  endtask

  task automatic test_add_imm();
    logic [15:0] init [2] = '{16'hFFFF, 16'h7FFF};
    logic [15:0] res  [2] = '{16'h0000, 16'h8000};
    logic [2:0]  cc   [2] = '{3'b010, 3'b100};
    for (int k = 0; k < 2; k++) begin
      set_reg(3'd1, init[k]);
      set_ir(16'h1261);
      SR1MUX = 1; SR2MUX = 1; ALUK = 2'd0; GateALU = 1; LD_REG = 1; LD_CC = 1;
      #1;
      checks++; if (bus !== res[k]) begin errors++; $display("FAIL add_bus[%0d]: got %h required %h", k, bus, res[k]); end
      step(); idle();
      checks++; if (nzp !== cc[k]) begin errors++; $display("FAIL add_nzp[%0d]: got %b required %b", k, nzp, cc[k]); end
      SR1MUX = 1; ALUK = 2'd3; GateALU = 1;
      #1;
      checks++; if (bus !== res[k]) begin errors++; $display("FAIL add_r1[%0d]: got %h required %h", k, bus, res[k]); end
      idle();
    end
  endtask

  task automatic test_ben();
    set_mdr(16'h0005); GateMDR = 1; LD_CC = 1; step(); idle();
    checks++; if (nzp !== 3'b001) begin errors++; $display("FAIL ben_setup_nzp: got %b required 001", nzp); end
    set_ir(16'h0A05); LD_BEN = 1; step(); idle();
    checks++; if (ben !== 1'b1) begin errors++; $display("FAIL ben_brnp: got %b required 1", ben); end
    set_ir(16'h0805); LD_BEN = 1; step(); idle();
    checks++; if (ben !== 1'b0) begin errors++; $display("FAIL ben_brn: got %b required 0", ben); end
    set_ir(16'h0205); LD_CC = 1; LD_BEN = 1; step(); idle();
    checks++; if (ben !== 1'b1 || nzp !== 3'b010) begin
      errors++; $display("FAIL ben_with_cc: ben=%b nzp=%b required 1 010", ben, nzp); end
    set_mdr(16'h0405); GateMDR = 1; LD_IR = 1; LD_BEN = 1; step(); idle();
    checks++; if (ben !== 1'b0 || ir !== 16'h0405) begin
      errors++; $display("FAIL ben_with_ir: ben=%b ir=%h required 0 0405", ben, ir); end
    LD_BEN = 1; step(); idle();
    checks++; if (ben !== 1'b1) begin errors++; $display("FAIL ben_new_ir: got %b required 1", ben); end
  endtask

  task automatic test_addr_pc();
    set_pc(16'h3000);
    set_ir(16'h01FF);
    ADDR1MUX = 0; ADDR2MUX = 2'd2; PCMUX = 2'd2; LD_PC = 1; step(); idle();
    checks++; if (pc !== 16'h2FFF) begin errors++; $display("FAIL pc_offset9: got %h required 2fff", pc); end
    set_pc(16'hFFFF);
    PCMUX = 2'd0; LD_PC = 1; step(); idle();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL pc_wrap: got %h required 0000", pc); end
    GatePC = 1; LD_MAR = 1; PCMUX = 2'd0; LD_PC = 1; step(); idle();
    checks++; if (mar !== 16'h0000 || pc !== 16'h0001) begin
      errors++; $display("FAIL pc_gate_load: mar=%h pc=%h required 0000 0001", mar, pc); end
  endtask

  task automatic test_mem();
    idle(); MIO_EN = 1; MDR_In = 16'hBEEF; LD_MDR = 1; step(); idle();
    checks++; if (mdr !== 16'hBEEF) begin errors++; $display("FAIL mem_mdr: got %h required beef", mdr); end
    GateMDR = 1; LD_IR = 1; step(); idle();
    checks++; if (ir !== 16'hBEEF) begin errors++; $display("FAIL mem_ir: got %h required beef", ir); end
    LD_LED = 1; step(); idle();
    checks++; if (led !== 12'hEEF) begin errors++; $display("FAIL mem_led: got %h required eef", led); end
  endtask

  task automatic test_contention();
    set_mdr(16'h1234); GateMDR = 1; LD_MAR = 1; LD_CC = 1; step(); idle();
    checks++; if (mar !== 16'h1234 || nzp !== 3'b001) begin
      errors++; $display("FAIL cont_setup: mar=%h nzp=%b required 1234 001", mar, nzp); end
    GatePC = 1; GateALU = 1; LD_MAR = 1; LD_CC = 1;
    #1;
    checks++; if (bus !== 16'h0) begin errors++; $display("FAIL cont_bus: got %h required 0000", bus); end
    step(); idle();
    checks++; if (mar !== 16'h0 || bus_err !== 1'b1 || nzp !== 3'b010) begin
      errors++; $display("FAIL cont_load: mar=%h err=%b nzp=%b required 0000 1 010", mar, bus_err, nzp); end
    repeat (3) step();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL cont_sticky: got %b required 1", bus_err); end
    #3; Reset = 0;
    #1;
    checks++; if (bus_err !== 1'b0 || pc !== 16'h0 || mar !== 16'h0) begin
      errors++; $display("FAIL async_reset: err=%b pc=%h mar=%h required 0 0000 0000", bus_err, pc, mar); end
    model_reset();
    @(negedge Clk); Reset = 1;
    @(posedge Clk); #1;
  endtask

  task automatic test_random();
    int g;
    for (int it = 0; it < 400; it++) begin
      idle();
      g = $urandom_range(0, 9);
      case (g)
        0: GatePC = 1;
        1: GateMDR = 1;
        2: GateALU = 1;
        3, 4: GateMARMUX = 1;
        9: if ($urandom_range(0, 9) == 0) begin GateMDR = 1; GateMARMUX = 1; end
        default: ;
      endcase
      {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = 8'($urandom);
      {DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN} = 5'($urandom);
      ADDR2MUX = 2'($urandom); ALUK = 2'($urandom); PCMUX = 2'($urandom);
      MDR_In = 16'($urandom);
      #1;
      checks++; if (bus !== model_bus()) begin
        errors++; $display("FAIL rand_bus[%0d]: got %h required %h", it, bus, model_bus()); end
      step();
      checks++; if ({pc, ir, mar, mdr, led, nzp, ben, bus_err} !== {m_pc, m_ir, m_mar, m_mdr, m_led, m_nzp, m_ben, m_err}) begin
        errors++;
        $display("FAIL rand_state[%0d]: got pc=%h ir=%h mar=%h mdr=%h led=%h nzp=%b ben=%b err=%b required pc=%h ir=%h mar=%h mdr=%h led=%h nzp=%b ben=%b err=%b",
                 it, pc, ir, mar, mdr, led, nzp, ben, bus_err, m_pc, m_ir, m_mar, m_mdr, m_led, m_nzp, m_ben, m_err);
      end
    end
    idle();
  endtask

  initial begin
    Reset = 1;
    idle();
    test_reset();
    test_w24();
    test_add_imm();
    test_ben();
    test_addr_pc();
    test_mem();
    test_contention();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
